// File: rtl/fpu_short_pkg.sv
// rtl/fpu_short_pkg.sv - shared op encodings and FloPoCo exception codes for the short FP unit
package fpu_short_pkg;

   typedef enum logic [3:0] {
      FP_FROM_IEEE = 4'd0,
      FPCVT_FROM_I = 4'd1,
      FPCVT_FROM_U = 4'd2,
      FPMIN        = 4'd3,
      FPMAX        = 4'd4,
      FSGNJ        = 4'd5,
      FSGNJN       = 4'd6,
      FSGNJX       = 4'd7,
      FEQ          = 4'd8,
      FLT          = 4'd9,
      FLE          = 4'd10
   } fp_short_op_t;

   localparam logic [1:0] EXN_ZERO   = 2'b00;
   localparam logic [1:0] EXN_NORMAL = 2'b01;
   localparam logic [1:0] EXN_INF    = 2'b10;
   localparam logic [1:0] EXN_NAN    = 2'b11;

endpackage

// File: rtl/fp_short_unit_pipe_if.sv
// rtl/fp_short_unit_pipe_if.sv - issue/writeback bundle of the short FP unit
interface fp_short_unit_pipe_if
   import fpu_short_pkg::*;
#(
   parameter int ID_W  = 2,
   parameter int FP_W  = 34,
   parameter int INT_W = 32
);
   logic              issue_valid;
   logic              issue_ready;
   logic [ID_W-1:0]   issue_id;
   fp_short_op_t      op;
   logic [FP_W-1:0]   rs1;
   logic [FP_W-1:0]   rs2;
   logic [INT_W-1:0]  rs1_gp;
   logic              wb_done;
   logic [ID_W-1:0]   wb_id;
   logic [FP_W-1:0]   wb_rd;
   logic              wb_ack;

   modport master (
      output issue_valid, issue_id, op, rs1, rs2, rs1_gp, wb_ack,
      input  issue_ready, wb_done, wb_id, wb_rd
   );

   modport slave (
      input  issue_valid, issue_id, op, rs1, rs2, rs1_gp, wb_ack,
      output issue_ready, wb_done, wb_id, wb_rd
   );
endinterface

// File: rtl/fp_short_i2f.sv
// rtl/fp_short_i2f.sv - integer magnitude + sign to FloPoCo, leading-zero normalise and RNE round
module fp_short_i2f
   import fpu_short_pkg::*;
#(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int INT_W  = 32
) (
   input  logic [INT_W-1:0]            mag,
   input  logic                        sign,
   output logic [EXP_W+FRAC_W+2:0]     res
);
   localparam int LZC_W = $clog2(INT_W + 1);
   localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
   localparam int EXT_W = INT_W + FRAC_W + 2;

   logic [LZC_W-1:0]  lzc;
   logic [INT_W-1:0]  norm;
   logic [EXT_W-1:0]  ext;
   logic [FRAC_W-1:0] frac_t;
   logic              guard;
   logic              sticky;
   logic              rnd;
   logic [FRAC_W:0]   frac_r;
   logic [EXP_W+1:0]  exp_c;

   always_comb begin
      lzc = LZC_W'(INT_W);
      for (int i = 0; i < INT_W; i++) begin
         if (mag[i]) lzc = LZC_W'(INT_W - 1 - i);
      end
   end

   // Zero-extend below the integer so guard/sticky exist even when INT_W <= FRAC_W+1
   assign norm   = mag << lzc;
   assign ext    = {norm, (FRAC_W + 2)'(0)};
   assign frac_t = ext[EXT_W-2 -: FRAC_W];
   assign guard  = ext[INT_W];
   assign sticky = |ext[INT_W-1:0];
   assign rnd    = guard & (sticky | frac_t[0]);
   assign frac_r = {1'b0, frac_t} + (FRAC_W + 1)'(rnd);
   assign exp_c  = (EXP_W + 2)'(BIAS + INT_W - 1) - (EXP_W + 2)'(lzc)
                 + (EXP_W + 2)'(frac_r[FRAC_W]);

   always_comb begin
      if (!ext[EXT_W-1])
         res = '0;
      else if (exp_c >= (EXP_W + 2)'((1 << EXP_W) - 1))
         res = {EXN_INF, sign, {EXP_W{1'b1}}, FRAC_W'(0)};
      else
         res = {EXN_NORMAL, sign, exp_c[EXP_W-1:0], frac_r[FRAC_W-1:0]};
   end
endmodule

// File: rtl/fp_short_unit_pipe.sv
// rtl/fp_short_unit_pipe.sv - short FP ops on FloPoCo operands behind a back-pressured pipeline
// Optional FEQ/FLT/FLE comparator enabled by FP_SHORT_CMP_EN.
module fp_short_unit_pipe
   import fpu_short_pkg::*;
#(
   parameter int EXP_W      = 8,
   parameter int FRAC_W     = 23,
   parameter int INT_W      = 32,
   parameter int PIPE_DEPTH = 2,
   parameter int ID_W       = 2
) (
   input  logic               clk,
   input  logic               rst,
   fp_short_unit_pipe_if.slave bus
);
   localparam int FP_W   = EXP_W + FRAC_W + 3;
   localparam int IEEE_W = EXP_W + FRAC_W + 1;
   localparam logic [FP_W-1:0] CANON_NAN = {EXN_NAN, 1'b0, EXP_W'(0), 1'b1, (FRAC_W - 1)'(0)};

   typedef struct packed {
      logic            valid;
      logic [ID_W-1:0] id;
      logic [FP_W-1:0] rd;
   } stage_t;

   function automatic logic is_nan(input logic [FP_W-1:0] x);
      return x[FP_W-1 -: 2] == EXN_NAN;
   endfunction

   // Magnitude ordering key: exn ranks zero < normal < inf; zero ignores its leftover fields
   function automatic logic [FP_W-2:0] mag_key(input logic [FP_W-1:0] x);
      if (x[FP_W-1 -: 2] == EXN_ZERO) return '0;
      return {x[FP_W-1 -: 2], x[FP_W-4:0]};
   endfunction

   function automatic logic less(input logic [FP_W-1:0] a, input logic [FP_W-1:0] b);
      if (a[FP_W-3] != b[FP_W-3]) return a[FP_W-3];
      if (a[FP_W-3]) return mag_key(a) > mag_key(b);
      return mag_key(a) < mag_key(b);
   endfunction

   logic [IEEE_W-1:0] ieee;
   logic [EXP_W-1:0]  i_exp;
   logic [FRAC_W-1:0] i_frac;
   logic              is_int;
   logic [INT_W-1:0]  cvt_mag;
   logic [FP_W-1:0]   cvt_res;
   logic [FP_W-1:0]   res;
   logic              nan1;
   logic              nan2;

   assign ieee    = bus.rs1_gp[IEEE_W-1:0];
   assign i_exp   = ieee[FRAC_W +: EXP_W];
   assign i_frac  = ieee[FRAC_W-1:0];
   assign is_int  = (bus.op == FPCVT_FROM_I) && bus.rs1_gp[INT_W-1];
   assign cvt_mag = is_int ? -bus.rs1_gp : bus.rs1_gp;
   assign nan1    = is_nan(bus.rs1);
   assign nan2    = is_nan(bus.rs2);

   fp_short_i2f #(.EXP_W(EXP_W), .FRAC_W(FRAC_W), .INT_W(INT_W)) u_i2f (
      .mag  (cvt_mag),
      .sign (is_int),
      .res  (cvt_res)
   );

   always_comb begin
      res = bus.rs1;
      case (bus.op)
         FP_FROM_IEEE: begin
            if (&i_exp)
               res = {(i_frac != '0) ? EXN_NAN : EXN_INF, ieee};
            else if (i_exp == '0)
               res = {EXN_ZERO, ieee[IEEE_W-1], (IEEE_W - 1)'(0)};
            else
               res = {EXN_NORMAL, ieee};
         end
         FPCVT_FROM_I, FPCVT_FROM_U: res = cvt_res;
         FPMIN, FPMAX: begin
            if (nan1 && nan2)           res = CANON_NAN;
            else if (nan1)              res = bus.rs2;
            else if (nan2)              res = bus.rs1;
            else if (bus.op == FPMIN)   res = less(bus.rs2, bus.rs1) ? bus.rs2 : bus.rs1;
            else                        res = less(bus.rs1, bus.rs2) ? bus.rs2 : bus.rs1;
         end
         FSGNJ:  res[FP_W-3] = bus.rs2[FP_W-3];
         FSGNJN: res[FP_W-3] = ~bus.rs2[FP_W-3];
         FSGNJX: res[FP_W-3] = bus.rs1[FP_W-3] ^ bus.rs2[FP_W-3];
`ifdef FP_SHORT_CMP_EN
         FEQ, FLT, FLE: begin
            logic both_zero;
            logic eq;
            logic lt;
            both_zero = (mag_key(bus.rs1) == '0) && (mag_key(bus.rs2) == '0);
            eq = !nan1 && !nan2 && (both_zero ||
                 ((bus.rs1[FP_W-3] == bus.rs2[FP_W-3]) && (mag_key(bus.rs1) == mag_key(bus.rs2))));
            lt = !nan1 && !nan2 && !both_zero && less(bus.rs1, bus.rs2);
            res = {(FP_W - 1)'(0), (bus.op == FEQ) ? eq : (bus.op == FLT) ? lt : (lt || eq)};
         end
`endif
         default: ;
      endcase
   end

   stage_t              pipe [PIPE_DEPTH];
   logic [PIPE_DEPTH:0] adv;

   // A stage may load when it is empty or its content moves on this cycle
   always_comb begin
      adv = '0;
      adv[PIPE_DEPTH] = bus.wb_ack;
      for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
         adv[i] = !pipe[i].valid || adv[i+1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PIPE_DEPTH; i++) pipe[i] <= '0;
      end else begin
         if (adv[0]) pipe[0] <= {bus.issue_valid, bus.issue_id, res};
         for (int i = 1; i < PIPE_DEPTH; i++) begin
            if (adv[i]) pipe[i] <= pipe[i-1];
         end
      end
   end

   assign bus.issue_ready = adv[0];
   assign bus.wb_done     = pipe[PIPE_DEPTH-1].valid;
   assign bus.wb_id       = pipe[PIPE_DEPTH-1].id;
   assign bus.wb_rd       = pipe[PIPE_DEPTH-1].rd;
endmodule
